demux_1to8_buf: RTL and testbench
=================================

Name: demux_1to8_buf

Overview:
- Eight-lane demultiplexer: the distribution counterpart of the registered 8:1 mux path.
- Accepts one WIDTH-bit word per handshake on a single input stream. Routes it to one of eight output lanes chosen by sel.
- Each lane has a one-entry holding register with its own valid/ready handshake, so a stalled lane blocks only words addressed to it.
- Sits between a single upstream producer and eight independent downstream consumers.

Parameters:
- WIDTH, 8, data word width in bits.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- din  input  WIDTH  input data word
- sel  input  3  destination lane index, sampled with din
- in_valid  input  1  upstream word present
- in_ready  output  1  block can accept a word addressed to the current sel
- dout  output  8*WIDTH  lane k data on bits [k*WIDTH +: WIDTH]
- out_valid  output  8  lane k holds a valid word
- out_ready  input  8  lane k consumer accepts

Behaviour:
- Reset, applied when rst_n=0 at posedge clk:
  - out_valid=8'h00, dout=0 (all lanes), in_ready=0 during reset.
  - Internal pointer (optional feature) = 0.
  - Reset mid-transfer discards all held words. No partial state survives.
- Lane state: each lane is EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1).
- Input accept:
  - Accept = in_valid & in_ready.
  - in_ready is combinational: lane[t] EMPTY, or lane[t] FULL with out_ready[t]=1 in the same cycle (drain-and-refill), where t = effective target lane.
  - in_ready is independent of in_valid.
- Latency: a word accepted at edge N appears on dout lane t with out_valid[t]=1 after edge N, one cycle.
- Lane drain: out_valid[k] & out_ready[k] at an edge → lane k goes EMPTY, unless a new word for lane k is accepted at the same edge. In that case lane k stays FULL with the new word.
- Simultaneous events:
  - Drains on any subset of lanes and one accept can occur on the same edge.
  - Drains of non-target lanes are unaffected by the accept.
- Holding rule: while out_valid[k]=1 and out_ready[k]=0, dout lane k and out_valid[k] must stay stable.
- dout lane k holds its last value after draining. Consumers qualify it with out_valid[k].
- Ordering: words to the same lane exit in acceptance order. There is no ordering guarantee across lanes.
- At most one word is accepted per cycle. Total occupancy ranges 0..8.
- sel is ignored when in_valid=0. There is no X/Z output; all lanes are always driven.

Optional Feature:
- Macro DEMUX_AUTO_SEL_EN.
- Defined:
  - sel is ignored. Target lane = internal 3-bit pointer.
  - The pointer increments by 1 after each accepted word and wraps 7→0.
  - The pointer holds when there is no accept.
  - Reset sets the pointer to 0.
  - in_ready uses the pointer's lane.
- Not defined: target lane = sel and no pointer logic is present. The port list is identical in both builds.

Test Plan:
- Reset then steady routing: rst_n=0 for 2 cycles → out_valid=00, in_ready=0. Release, all out_ready=1, send din=8'hA0..8'hA7 with sel=0..7 on consecutive cycles → each lane k shows 8'hA0+k with out_valid[k]=1 exactly one cycle after its accept. in_ready=1 throughout.
- Backpressure on one lane: out_ready[3]=0, send 8'h11 to sel=3 → lane 3 FULL. A second word 8'h22 to sel=3 → in_ready=0 and the word is not taken. Meanwhile sel=5 with 8'h55 → accepted, lane 5 shows 8'h55 next cycle. Lane 3 holds 8'h11 stable.
- Drain-and-refill: lane 2 FULL with 8'h33, out_ready[2]=1 and in_valid=1, sel=2, din=8'h44 on the same edge → in_ready=1, lane 2 shows 8'h44 next cycle with out_valid[2] continuously 1.
- All lanes full: fill lanes 0..7 with out_ready=0 → out_valid=FF, in_ready=0 for every sel. Raise out_ready[6] only → in_ready=1 for sel=6, 0 for others.
- Reset mid-operation: lanes 1,4 FULL, assert rst_n=0 for one edge → out_valid=00 next cycle. The held words never reappear.
- DEMUX_AUTO_SEL_EN build: sel tied to 7, send 10 words 8'h00..8'h09 with all out_ready=1 → words land on lanes 0,1,…,7,0,1 (wrap at the 9th). Stall lane 1 with a word present before the 10th word → in_ready=0, and the pointer stays at 1 until lane 1 drains.

Source files
------------

// File: rtl/demux_1to8_buf.sv
// 1-to-8 demultiplexer with a one-entry valid/ready holding register per output lane.
// Optional build macro DEMUX_AUTO_SEL_EN: route by an internal round-robin pointer instead of sel.

module demux_1to8_buf_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             out_valid_o,
    output logic             can_take_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // A load on the same edge as a drain wins, so the lane stays full with the new word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && out_ready_i)
            valid_d = 1'b0;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign can_take_o  = !valid_q || out_ready_i;
    assign dout_o      = data_q;
    assign out_valid_o = valid_q;

endmodule

module demux_1to8_buf #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic [2:0]           sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [8*WIDTH-1:0]   dout,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready
);

    localparam int NUM_LANES = 8;

    logic [2:0]           tgt;
    logic                 accept;
    logic [NUM_LANES-1:0] can_take;
    logic [NUM_LANES-1:0] load;

`ifdef DEMUX_AUTO_SEL_EN
    logic [2:0] ptr_q, ptr_d;
    logic       unused_sel;

    assign unused_sel = ^sel;

    // 3-bit pointer wraps 7->0 naturally.
    always_comb begin
        ptr_d = ptr_q;
        if (accept)
            ptr_d = ptr_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr_q <= 3'd0;
        else
            ptr_q <= ptr_d;
    end

    assign tgt = ptr_q;
`else
    assign tgt = sel;
`endif

    // Held low during reset so nothing is accepted while lanes are being cleared.
    assign in_ready = rst_n && can_take[tgt];
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign load[k] = accept && (tgt == 3'(k));

        demux_1to8_buf_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_i      (load[k]),
            .din_i       (din),
            .out_ready_i (out_ready[k]),
            .dout_o      (dout[k*WIDTH +: WIDTH]),
            .out_valid_o (out_valid[k]),
            .can_take_o  (can_take[k])
        );
    end

endmodule

// File: tb/tb_demux_1to8_buf.sv
// Directed + random check of demux_1to8_buf against a per-lane occupancy model.
// Honours DEMUX_AUTO_SEL_EN to select the pointer-routed reference behaviour.

module tb_demux_1to8_buf;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic [2:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dout;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;

    demux_1to8_buf #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference: each lane is a one-slot mailbox; last written word is kept after drain.
    bit       m_full [8];
    bit [7:0] m_data [8];
    int       m_ptr;

    function automatic logic [63:0] m_dout();
        logic [63:0] v = '0;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = m_data[k];
        return v;
    endfunction

    function automatic logic [7:0] m_valid();
        logic [7:0] v = '0;
        for (int k = 0; k < 8; k++) v[k] = m_full[k];
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n     = 1'b0;
        in_valid  = 1'($urandom);
        sel       = 3'($urandom);
        din       = 8'($urandom);
        out_ready = 8'($urandom);
        #1;
        check("in_ready_in_reset", 64'(in_ready), 64'd0);
        repeat (cycles) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = 8'h00;
        end
        m_ptr = 0;
        check("in_ready_in_reset", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_dout", dout, 64'd0);
        rst_n = 1'b1;
    endtask

    task automatic cycle(input logic v, input logic [2:0] s, input logic [7:0] d,
                         input logic [7:0] ordy);
        int  t;
        bit  exp_rdy;
        bit  acc;
        in_valid  = v;
        sel       = s;
        din       = d;
        out_ready = ordy;
`ifdef DEMUX_AUTO_SEL_EN
        t = m_ptr;
`else
        t = int'(s);
`endif
        exp_rdy = !m_full[t] || ordy[t];
        acc     = v && exp_rdy;
        #1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        for (int k = 0; k < 8; k++)
            if (m_full[k] && ordy[k]) m_full[k] = 1'b0;
        if (acc) begin
            m_full[t] = 1'b1;
            m_data[t] = d;
            m_ptr     = (m_ptr + 1) % 8;
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid()));
        check("dout", dout, m_dout());
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; sel = '0; din = '0; out_ready = '0;
        m_ptr = 0;
        @(negedge clk);
        do_reset(2);

`ifdef DEMUX_AUTO_SEL_EN
        // Round robin with wrap; sel tied high is ignored.
        for (int i = 0; i < 10; i++) cycle(1'b1, 3'd7, 8'(i), 8'hFF);
        do_reset(1);
        // Lane 1 stalls holding word 1; pointer must park on lane 1.
        for (int i = 0; i < 9; i++) cycle(1'b1, 3'd7, 8'(i), 8'hFD);
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd7, 8'h09, 8'hFD);
        cycle(1'b1, 3'd7, 8'h09, 8'hFF);
        cycle(1'b1, 3'd7, 8'h0A, 8'hFF);
`else
        // Steady routing to every lane.
        for (int k = 0; k < 8; k++) cycle(1'b1, 3'(k), 8'hA0 + 8'(k), 8'hFF);
        // Backpressure on lane 3 only.
        cycle(1'b1, 3'd3, 8'h11, 8'hF7);
        cycle(1'b1, 3'd3, 8'h22, 8'hF7);
        cycle(1'b1, 3'd5, 8'h55, 8'hF7);
        cycle(1'b0, 3'd3, 8'h66, 8'hF7);
        // Drain-and-refill on lane 2.
        cycle(1'b1, 3'd2, 8'h33, 8'hF3);
        cycle(1'b1, 3'd2, 8'h44, 8'hF7);
        // All lanes full, then open only lane 6.
        for (int k = 0; k < 8; k++) cycle(1'b1, 3'(k), 8'hC0 + 8'(k), 8'h00);
        for (int k = 0; k < 8; k++) cycle(1'b1, 3'(k), 8'hD0 + 8'(k), 8'h00);
        cycle(1'b1, 3'd6, 8'hE6, 8'h40);
        cycle(1'b1, 3'd0, 8'hE0, 8'h40);
        cycle(1'b1, 3'd6, 8'hE7, 8'h00);
        cycle(1'b1, 3'd6, 8'hE8, 8'h40);
`endif
        // Reset with lanes holding words: nothing may reappear.
        cycle(1'b1, 3'd1, 8'h71, 8'h00);
        cycle(1'b1, 3'd4, 8'h74, 8'h00);
        do_reset(1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 8'h00, 8'hFF);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(63) == 0)
                do_reset(1);
            else
                cycle(1'($urandom_range(3) != 0), 3'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
